// File: rtl/lut_mult_ctrl.sv
// Quarter-square multiplier controller: drives two external 1-cycle LUTs with
// |A+B| and |A-B| addresses and forms A*B = q(A+B) - q(|A-B|) in a 3-stage pipeline.
module lut_mult_ctrl (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic [6:0]  A_In,
  input  logic [6:0]  B_In,
  input  logic        In_Valid,
  output logic        In_Ready,
  output logic [7:0]  Addr_Sum,
  output logic [7:0]  Addr_Diff,
  input  logic [15:0] Q_Sum,
  input  logic [15:0] Q_Diff,
  output logic [15:0] Product,
  output logic        Out_Valid,
  input  logic        Out_Ready,
  output logic        Busy
);

  logic        en;
  logic        v1;
  logic        v2;
  logic        held;
  logic [15:0] hold_diff;
  logic [15:0] q_delta;
  logic [7:0]  sum_nxt;
  logic [7:0]  diff_nxt;

  assign en       = !Out_Valid || Out_Ready;
  assign In_Ready = en;
  assign Busy     = v1 | v2 | Out_Valid;
  assign q_delta  = Q_Sum - Q_Diff;

  always_comb begin
    sum_nxt  = {1'b0, A_In} + {1'b0, B_In};
    diff_nxt = '0;
    if (B_In > A_In)
      diff_nxt = {1'b0, B_In - A_In};
    else
      diff_nxt = {1'b0, A_In - B_In};
  end

  // The LUTs re-register from the (held) S1 address on every stall edge, which
  // overwrites the S2 result; capture it on the first stall edge and use it on resume.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      Out_Valid <= 1'b0;
      Addr_Sum  <= '0;
      Addr_Diff <= '0;
      Product   <= '0;
      held      <= 1'b0;
      hold_diff <= '0;
    end else if (en) begin
      if (In_Valid) begin
        Addr_Sum  <= sum_nxt;
        Addr_Diff <= diff_nxt;
        v1        <= 1'b1;
      end else begin
        v1        <= 1'b0;
      end
      v2        <= v1;
      Out_Valid <= v2;
      if (v2)
        Product <= held ? hold_diff : q_delta;
      held <= 1'b0;
    end else if (v2 && !held) begin
      hold_diff <= q_delta;
      held      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lut_mult_ctrl.sv
// Directed self-checking bench for lut_mult_ctrl with behavioural quarter-square LUTs.
module tb_lut_mult_ctrl;

  logic        CLK;
  logic        RSTn;
  logic [6:0]  A_In;
  logic [6:0]  B_In;
  logic        In_Valid;
  logic        In_Ready;
  logic [7:0]  Addr_Sum;
  logic [7:0]  Addr_Diff;
  logic [15:0] Q_Sum;
  logic [15:0] Q_Diff;
  logic [15:0] Product;
  logic        Out_Valid;
  logic        Out_Ready;
  logic        Busy;

  int checks;
  int errors;

  lut_mult_ctrl dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .A_In      (A_In),
    .B_In      (B_In),
    .In_Valid  (In_Valid),
    .In_Ready  (In_Ready),
    .Addr_Sum  (Addr_Sum),
    .Addr_Diff (Addr_Diff),
    .Q_Sum     (Q_Sum),
    .Q_Diff    (Q_Diff),
    .Product   (Product),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready),
    .Busy      (Busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // External LUTs: registered floor(n*n/4), no enable.
  always_ff @(posedge CLK) begin
    Q_Sum  <= 16'((int'(Addr_Sum) * int'(Addr_Sum)) / 4);
    Q_Diff <= 16'((int'(Addr_Diff) * int'(Addr_Diff)) / 4);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RSTn = 1'b0; A_In = '0; B_In = '0; In_Valid = 1'b0; Out_Ready = 1'b1;
    tick();
    tick();
    checks++; if (Out_Valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", Out_Valid); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", Busy); end
    checks++; if (In_Ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b expected 1", In_Ready); end
    checks++; if (Addr_Sum !== 8'd0) begin errors++; $display("FAIL reset_addr_sum: got %0d expected 0", Addr_Sum); end
    checks++; if (Addr_Diff !== 8'd0) begin errors++; $display("FAIL reset_addr_diff: got %0d expected 0", Addr_Diff); end
    checks++; if (Product !== 16'd0) begin errors++; $display("FAIL reset_product: got %0d expected 0", Product); end
    RSTn = 1'b1;
    tick();
  endtask

  task automatic test_single(input logic [6:0] a, input logic [6:0] b,
                             input logic [7:0] exp_sum, input logic [7:0] exp_diff,
                             input logic [15:0] exp_prod);
    A_In = a; B_In = b; In_Valid = 1'b1; Out_Ready = 1'b1;
    #1;
    checks++; if (In_Ready !== 1'b1) begin errors++; $display("FAIL single_in_ready(%0d,%0d): got %0b expected 1", a, b, In_Ready); end
    tick();
    In_Valid = 1'b0;
    checks++; if (Addr_Sum !== exp_sum) begin errors++; $display("FAIL single_addr_sum(%0d,%0d): got %0d expected %0d", a, b, Addr_Sum, exp_sum); end
    checks++; if (Addr_Diff !== exp_diff) begin errors++; $display("FAIL single_addr_diff(%0d,%0d): got %0d expected %0d", a, b, Addr_Diff, exp_diff); end
    checks++; if (Out_Valid !== 1'b0) begin errors++; $display("FAIL single_early_valid1(%0d,%0d): got %0b expected 0", a, b, Out_Valid); end
    tick();
    checks++; if (Out_Valid !== 1'b0) begin errors++; $display("FAIL single_early_valid2(%0d,%0d): got %0b expected 0", a, b, Out_Valid); end
    checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL single_busy(%0d,%0d): got %0b expected 1", a, b, Busy); end
    tick();
    checks++; if (Out_Valid !== 1'b1) begin errors++; $display("FAIL single_out_valid(%0d,%0d): got %0b expected 1", a, b, Out_Valid); end
    checks++; if (Product !== exp_prod) begin errors++; $display("FAIL single_product(%0d,%0d): got %0d expected %0d", a, b, Product, exp_prod); end
    tick();
    checks++; if (Out_Valid !== 1'b0) begin errors++; $display("FAIL single_dup(%0d,%0d): got %0b expected 0", a, b, Out_Valid); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL single_idle(%0d,%0d): got %0b expected 0", a, b, Busy); end
  endtask

  task automatic test_back_to_back();
    logic [6:0]  av [3] = '{7'd3, 7'd100, 7'd127};
    logic [6:0]  bv [3] = '{7'd10, 7'd27, 7'd127};
    logic [15:0] pv [3] = '{16'd30, 16'd2700, 16'd16129};
    Out_Ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      A_In = av[i]; B_In = bv[i]; In_Valid = 1'b1;
      tick();
    end
    In_Valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (Out_Valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %0b expected 1", i, Out_Valid); end
      checks++; if (Product !== pv[i]) begin errors++; $display("FAIL b2b_product[%0d]: got %0d expected %0d", i, Product, pv[i]); end
      tick();
    end
    checks++; if (Out_Valid !== 1'b0) begin errors++; $display("FAIL b2b_tail: got %0b expected 0", Out_Valid); end
    tick();
  endtask

  task automatic test_stall();
    logic [6:0]  av [3] = '{7'd3, 7'd100, 7'd127};
    logic [6:0]  bv [3] = '{7'd10, 7'd27, 7'd127};
    logic [15:0] pv [3] = '{16'd2700, 16'd16129, 16'd81};
    Out_Ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      A_In = av[i]; B_In = bv[i]; In_Valid = 1'b1;
      tick();
    end
    // First result is out; stall with a fourth pair (9,9) waiting at the input.
    Out_Ready = 1'b0; A_In = 7'd9; B_In = 7'd9; In_Valid = 1'b1;
    #1;
    checks++; if (In_Ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready0: got %0b expected 0", In_Ready); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (Out_Valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %0b expected 1", i, Out_Valid); end
      checks++; if (Product !== 16'd30) begin errors++; $display("FAIL stall_product[%0d]: got %0d expected 30", i, Product); end
      checks++; if (In_Ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d]: got %0b expected 0", i, In_Ready); end
      checks++; if (Addr_Sum !== 8'd254) begin errors++; $display("FAIL stall_addr_hold[%0d]: got %0d expected 254", i, Addr_Sum); end
    end
    Out_Ready = 1'b1;
    #1;
    checks++; if (In_Ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready: got %0b expected 1", In_Ready); end
    tick();
    In_Valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (Out_Valid !== 1'b1) begin errors++; $display("FAIL stall_drain_valid[%0d]: got %0b expected 1", i, Out_Valid); end
      checks++; if (Product !== pv[i]) begin errors++; $display("FAIL stall_drain_product[%0d]: got %0d expected %0d", i, Product, pv[i]); end
      tick();
    end
    checks++; if (Out_Valid !== 1'b0) begin errors++; $display("FAIL stall_no_dup: got %0b expected 0", Out_Valid); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL stall_idle: got %0b expected 0", Busy); end
    tick();
  endtask

  task automatic test_reset_midflight();
    Out_Ready = 1'b1;
    A_In = 7'd3; B_In = 7'd10; In_Valid = 1'b1;
    tick();
    A_In = 7'd100; B_In = 7'd27;
    tick();
    In_Valid = 1'b0;
    checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %0b expected 1", Busy); end
    #2;
    RSTn = 1'b0;
    #1;
    checks++; if (Out_Valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %0b expected 0", Out_Valid); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %0b expected 0", Busy); end
    checks++; if (In_Ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %0b expected 1", In_Ready); end
    checks++; if (Addr_Sum !== 8'd0) begin errors++; $display("FAIL midrst_addr_sum: got %0d expected 0", Addr_Sum); end
    tick();
    RSTn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (Out_Valid !== 1'b0) begin errors++; $display("FAIL midrst_stale[%0d]: got %0b expected 0", i, Out_Valid); end
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL midrst_stale_busy[%0d]: got %0b expected 0", i, Busy); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single(7'd100, 7'd27, 8'd127, 8'd73, 16'd2700);
    test_single(7'd127, 7'd127, 8'd254, 8'd0, 16'd16129);
    test_single(7'd0, 7'd55, 8'd55, 8'd55, 16'd0);
    test_single(7'd3, 7'd10, 8'd13, 8'd7, 16'd30);
    test_back_to_back();
    test_stall();
    test_reset_midflight();
    test_single(7'd12, 7'd11, 8'd23, 8'd1, 16'd132);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
